dr_adder_port: RTL and testbench
================================

Name: dr_adder_port

Overview:
- Synchronous front/back-end for the asynchronous dual-rail (positive rail-pair, return-to-zero) WIDTH-bit adder built from the *_pdr cells.
- Accepts single-rail operands on a valid/ready interface and drives them onto the adder's dual-rail inputs as data then spacer.
- Synchronizes the adder's dual-rail sum/carry, detects completion and return-to-spacer, and presents a single-rail result on a valid/ready interface.

Parameters:
WIDTH, 4, operand/sum width
SYNC_STAGES, 2, synchronizer flops on every async input rail (>=2)
SETTLE, 2, consecutive identical complete (or all-zero) samples required (>=1)
TIMEOUT, 255, max cycles in EVAL or SPACER before forced exit (8-bit counter)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand request
in_ready  out  1  block can accept operands
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_cin  in  1  carry in
dr_a_1, dr_a_0  out  WIDTH each  dual-rail A to adder
dr_b_1, dr_b_0  out  WIDTH each  dual-rail B to adder
dr_cin_1, dr_cin_0  out  1 each  dual-rail carry in
dr_s_1, dr_s_0  in  WIDTH each  dual-rail sum from adder (async)
dr_cout_1, dr_cout_0  in  1 each  dual-rail carry out (async)
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_sum  out  WIDTH  decoded sum
out_cout  out  1  decoded carry out
out_err  out  1  result invalid (illegal code or EVAL timeout), qualified by out_valid
spacer_err  out  1  sticky: SPACER timed out

Behaviour:
- Reset: the only clock is clk. rst is synchronous and active-high. Synchronous reset clears all dr_* outputs to 0 (spacer), synchronizers, counters, out_valid, out_sum, out_cout, out_err and spacer_err. State goes to SPACER. in_ready=0 while rst is high.
- States: SPACER -> IDLE -> EVAL -> HOLD -> SPACER.
- Bit codes:
  - A bit is valid when exactly one rail is high; value = rail_1.
  - A bit is illegal when both rails are high.
  - Empty means all rails are 0.
  - "Sample" means the synchronized value, SYNC_STAGES cycles old.
- IDLE:
  - in_ready=1 (combinational decode of state, gated by ~rst).
  - On in_valid&in_ready at edge E0: register dr_x_1=x and dr_x_0=~x for A, B and cin; go to EVAL.
- EVAL:
  - A settle counter increments each cycle the sample has all WIDTH+1 bits valid and equals the previous sample.
  - Any incomplete or changed sample resets the counter to 0.
  - When the counter reaches SETTLE: latch the decoded sum/cout, out_err=0, go to HOLD.
  - With a zero-delay adder, out_valid rises after edge E0+SYNC_STAGES+SETTLE (E4 with defaults).
  - Any illegal bit in a sample: go to HOLD immediately with out_err=1, out_sum=0, out_cout=0.
  - TIMEOUT cycles in EVAL without completion: same as illegal (out_err=1).
  - Illegal detection takes priority over completion in the same cycle.
- HOLD:
  - out_valid=1; out_sum, out_cout and out_err are stable.
  - dr_* inputs keep the data codeword.
  - On out_valid&out_ready at edge H: clear out_valid, drive all dr_* to 0, go to SPACER.
  - out_ready may be high in the same cycle out_valid first rises; the handshake completes at that edge.
- SPACER:
  - Wait until the sample is empty for SETTLE consecutive cycles, then go to IDLE.
  - Zero-delay: in_ready=1 after edge H+SYNC_STAGES+SETTLE.
  - Both-rails-high in SPACER counts as non-empty.
  - TIMEOUT cycles: set spacer_err (sticky until rst), go to IDLE anyway.
- Throughput: one operation in flight; no operand buffering.
- Timeout counter: resets on every state entry; saturates, no wrap.
- rst mid-operation: abandons the operation; the outstanding result is never presented. The post-reset SPACER state guarantees the adder has returned to empty before new data is driven.

Test Plan:
- Reset with adder model held empty -> dr_* all 0, out_valid=0, spacer_err=0; in_ready=1 exactly SYNC_STAGES+SETTLE cycles after rst deasserts.
- a=5, b=9, cin=0, zero-delay adder -> out_sum=14, out_cout=0, out_err=0; out_valid at E0+4; dr_a_1=0101, dr_a_0=1010.
- a=15, b=1, cin=1, out_ready low 10 cycles -> out_sum=1, out_cout=1 held stable; dr_* keep data until handshake, then all 0; in_ready returns 4 cycles after handshake.
- Adder model releases sum bits skewed by 1,3,6 cycles with a glitched intermediate value -> counter restarts; result = final value only (a=3, b=4 -> 7).
- Model drives dr_s_1[2]=dr_s_0[2]=1 -> out_valid with out_err=1, out_sum=0; block then completes SPACER normally.
- Model never completes -> out_err=1 after 255 EVAL cycles. Model stuck non-empty after handshake -> spacer_err=1 after 255 cycles, in_ready=1, spacer_err persists until rst.

Source files
------------

// File: rtl/dr_adder_port_if.sv
`default_nettype none
// ============================================================================
// Module      : dr_adder_port_if
// Description : Operand/result handshake plus dual-rail adder connection
//               bundle for dr_adder_port.
// Revision    : 1.0 - initial release
// ============================================================================
interface dr_adder_port_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;

    logic [WIDTH-1:0] dr_a_1;
    logic [WIDTH-1:0] dr_a_0;
    logic [WIDTH-1:0] dr_b_1;
    logic [WIDTH-1:0] dr_b_0;
    logic             dr_cin_1;
    logic             dr_cin_0;
    logic [WIDTH-1:0] dr_s_1;
    logic [WIDTH-1:0] dr_s_0;
    logic             dr_cout_1;
    logic             dr_cout_0;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_err;
    logic             spacer_err;

    modport slave (
        input  in_valid, in_a, in_b, in_cin,
        output in_ready,
        output dr_a_1, dr_a_0, dr_b_1, dr_b_0, dr_cin_1, dr_cin_0,
        input  dr_s_1, dr_s_0, dr_cout_1, dr_cout_0,
        output out_valid, out_sum, out_cout, out_err, spacer_err,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_cin,
        input  in_ready,
        input  dr_a_1, dr_a_0, dr_b_1, dr_b_0, dr_cin_1, dr_cin_0,
        output dr_s_1, dr_s_0, dr_cout_1, dr_cout_0,
        input  out_valid, out_sum, out_cout, out_err, spacer_err,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/dr_adder_port.sv
`default_nettype none
// ============================================================================
// Module      : dr_adder_port
// Description : Synchronous front/back-end for a dual-rail return-to-zero
//               adder: drives operands as data/spacer, synchronizes and
//               decodes the result with completion and timeout detection.
// Revision    : 1.0 - initial release
// ============================================================================
module dr_adder_port #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 2,
    parameter int TIMEOUT     = 255
) (
    input  wire logic      clk,
    input  wire logic      rst,
    dr_adder_port_if.slave bus
);
    localparam int              c_W1       = WIDTH + 1;
    localparam int              c_DW       = 2 * WIDTH + 1;
    localparam int              c_SW       = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [c_SW-1:0] c_SETTLE   = c_SW'(SETTLE);
    localparam logic [7:0]      c_TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_SPACER = 2'd0,
        ST_IDLE   = 2'd1,
        ST_EVAL   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [2*c_W1-1:0]     r_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] r_fill;
    logic [2*c_W1-1:0]     r_prev;
    logic [c_SW-1:0]       r_settle, w_settle_nxt, w_settle_inc;
    logic [7:0]            r_tmo, w_tmo_nxt;
    logic [c_DW-1:0]       r_dr1, r_dr0, w_dr1_nxt, w_dr0_nxt;
    logic                  r_out_valid, w_out_valid_nxt;
    logic [WIDTH-1:0]      r_out_sum, w_out_sum_nxt;
    logic                  r_out_cout, w_out_cout_nxt;
    logic                  r_out_err, w_out_err_nxt;
    logic                  r_spacer_err, w_spacer_err_nxt;

    logic [2*c_W1-1:0] w_raw, w_smp;
    logic [c_W1-1:0]   w_r1, w_r0;
    logic              w_live, w_complete, w_illegal, w_empty, w_same, w_run, w_done;

    assign w_raw = {bus.dr_cout_1, bus.dr_s_1, bus.dr_cout_0, bus.dr_s_0};

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) r_sync[gi] <= '0;
                    else     r_sync[gi] <= w_raw;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) r_sync[gi] <= '0;
                    else     r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    // Samples only count once the synchronizer holds live data again after reset
    always_ff @(posedge clk) begin
        if (rst) r_fill <= '0;
        else     r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end

    assign w_smp      = r_sync[SYNC_STAGES-1];
    assign w_r1       = w_smp[2*c_W1-1:c_W1];
    assign w_r0       = w_smp[c_W1-1:0];
    assign w_live     = r_fill[SYNC_STAGES-1];
    assign w_complete = &(w_r1 ^ w_r0);
    assign w_illegal  = |(w_r1 & w_r0);
    assign w_empty    = ~|(w_r1 | w_r0);
    assign w_same     = (w_smp == r_prev);

    // A complete (or empty) sample that differs from the last one starts a new run of 1
    always_comb begin
        w_run = w_live && (((r_state == ST_EVAL) && w_complete) ||
                           ((r_state == ST_SPACER) && w_empty));
        if (!w_run)                          w_settle_inc = '0;
        else if ((r_settle != '0) && w_same) w_settle_inc = r_settle + c_SW'(1);
        else                                 w_settle_inc = c_SW'(1);
        w_done = w_run && (w_settle_inc == c_SETTLE);
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_dr1_nxt        = r_dr1;
        w_dr0_nxt        = r_dr0;
        w_out_valid_nxt  = r_out_valid;
        w_out_sum_nxt    = r_out_sum;
        w_out_cout_nxt   = r_out_cout;
        w_out_err_nxt    = r_out_err;
        w_spacer_err_nxt = r_spacer_err;
        w_settle_nxt     = w_settle_inc;
        w_tmo_nxt        = (r_tmo == 8'hFF) ? r_tmo : r_tmo + 8'd1;

        case (r_state)
            ST_SPACER: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_tmo >= c_TMO_LAST) begin
                    w_state_nxt      = ST_IDLE;
                    w_spacer_err_nxt = 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_dr1_nxt   = {bus.in_cin, bus.in_b, bus.in_a};
                    w_dr0_nxt   = ~{bus.in_cin, bus.in_b, bus.in_a};
                    w_state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (w_live && w_illegal) begin
                    w_state_nxt     = ST_HOLD;
                    w_out_valid_nxt = 1'b1;
                    w_out_err_nxt   = 1'b1;
                    w_out_sum_nxt   = '0;
                    w_out_cout_nxt  = 1'b0;
                end else if (w_done) begin
                    w_state_nxt     = ST_HOLD;
                    w_out_valid_nxt = 1'b1;
                    w_out_err_nxt   = 1'b0;
                    w_out_sum_nxt   = w_r1[WIDTH-1:0];
                    w_out_cout_nxt  = w_r1[WIDTH];
                end else if (r_tmo >= c_TMO_LAST) begin
                    w_state_nxt     = ST_HOLD;
                    w_out_valid_nxt = 1'b1;
                    w_out_err_nxt   = 1'b1;
                    w_out_sum_nxt   = '0;
                    w_out_cout_nxt  = 1'b0;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    w_state_nxt     = ST_SPACER;
                    w_out_valid_nxt = 1'b0;
                    w_dr1_nxt       = '0;
                    w_dr0_nxt       = '0;
                end
            end
            default: w_state_nxt = ST_SPACER;
        endcase

        if (w_state_nxt != r_state) begin
            w_settle_nxt = '0;
            w_tmo_nxt    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_SPACER;
            r_prev       <= '0;
            r_settle     <= '0;
            r_tmo        <= '0;
            r_dr1        <= '0;
            r_dr0        <= '0;
            r_out_valid  <= 1'b0;
            r_out_sum    <= '0;
            r_out_cout   <= 1'b0;
            r_out_err    <= 1'b0;
            r_spacer_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev       <= w_smp;
            r_settle     <= w_settle_nxt;
            r_tmo        <= w_tmo_nxt;
            r_dr1        <= w_dr1_nxt;
            r_dr0        <= w_dr0_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_sum    <= w_out_sum_nxt;
            r_out_cout   <= w_out_cout_nxt;
            r_out_err    <= w_out_err_nxt;
            r_spacer_err <= w_spacer_err_nxt;
        end
    end

    assign bus.in_ready   = (r_state == ST_IDLE) && !rst;
    assign bus.dr_a_1     = r_dr1[WIDTH-1:0];
    assign bus.dr_a_0     = r_dr0[WIDTH-1:0];
    assign bus.dr_b_1     = r_dr1[2*WIDTH-1:WIDTH];
    assign bus.dr_b_0     = r_dr0[2*WIDTH-1:WIDTH];
    assign bus.dr_cin_1   = r_dr1[2*WIDTH];
    assign bus.dr_cin_0   = r_dr0[2*WIDTH];
    assign bus.out_valid  = r_out_valid;
    assign bus.out_sum    = r_out_sum;
    assign bus.out_cout   = r_out_cout;
    assign bus.out_err    = r_out_err;
    assign bus.spacer_err = r_spacer_err;
endmodule
`default_nettype wire

// File: tb/tb_dr_adder_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_dr_adder_port
// Description : Directed self-checking bench for dr_adder_port with a
//               zero-delay dual-rail adder model and a manual rail override.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dr_adder_port;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    // 0: zero-delay adder, 1: rails driven directly from m_*
    logic       mode = 1'b0;
    logic [3:0] m_s1 = '0, m_s0 = '0;
    logic       m_c1 = 1'b0, m_c0 = 1'b0;

    dr_adder_port_if #(.WIDTH(4)) bus ();

    dr_adder_port #(
        .WIDTH(4), .SYNC_STAGES(2), .SETTLE(2), .TIMEOUT(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        logic [4:0] t;
        t             = '0;
        bus.dr_s_1    = '0;
        bus.dr_s_0    = '0;
        bus.dr_cout_1 = 1'b0;
        bus.dr_cout_0 = 1'b0;
        if (mode) begin
            bus.dr_s_1    = m_s1;
            bus.dr_s_0    = m_s0;
            bus.dr_cout_1 = m_c1;
            bus.dr_cout_0 = m_c0;
        end else if ((&(bus.dr_a_1 | bus.dr_a_0)) && (&(bus.dr_b_1 | bus.dr_b_0)) &&
                     (bus.dr_cin_1 | bus.dr_cin_0)) begin
            t             = {1'b0, bus.dr_a_1} + {1'b0, bus.dr_b_1} + {4'd0, bus.dr_cin_1};
            bus.dr_s_1    = t[3:0];
            bus.dr_s_0    = ~t[3:0];
            bus.dr_cout_1 = t[4];
            bus.dr_cout_0 = ~t[4];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic op_start(input logic [3:0] a, input logic [3:0] b, input logic cin);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ready(input int n);
        for (int i = 1; i < n; i++) begin
            step();
            check("in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        end
        step();
        check("in_ready_high", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset with the adder empty
        repeat (3) step();
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_dr_a_1", {28'd0, bus.dr_a_1}, 32'd0);
        check("rst_dr_a_0", {28'd0, bus.dr_a_0}, 32'd0);
        check("rst_dr_cin", {30'd0, bus.dr_cin_1, bus.dr_cin_0}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_spacer_err", {31'd0, bus.spacer_err}, 32'd0);
        rst = 1'b0;
        wait_ready(4);

        // 5 + 9 + 0 = 14
        op_start(4'd5, 4'd9, 1'b0);
        check("t2_dr_a_1", {28'd0, bus.dr_a_1}, 32'h5);
        check("t2_dr_a_0", {28'd0, bus.dr_a_0}, 32'hA);
        check("t2_dr_b_0", {28'd0, bus.dr_b_0}, 32'h6);
        check("t2_in_ready", {31'd0, bus.in_ready}, 32'd0);
        step(); step(); step();
        check("t2_valid_e3", {31'd0, bus.out_valid}, 32'd0);
        step();
        check("t2_valid_e4", {31'd0, bus.out_valid}, 32'd1);
        check("t2_sum", {28'd0, bus.out_sum}, 32'd14);
        check("t2_cout", {31'd0, bus.out_cout}, 32'd0);
        check("t2_err", {31'd0, bus.out_err}, 32'd0);
        handshake();
        check("t2_valid_off", {31'd0, bus.out_valid}, 32'd0);
        check("t2_dr_a_1_sp", {28'd0, bus.dr_a_1}, 32'd0);
        wait_ready(4);

        // 15 + 1 + 1 = 17, consumer stalls 10 cycles
        op_start(4'd15, 4'd1, 1'b1);
        repeat (4) step();
        check("t3_valid", {31'd0, bus.out_valid}, 32'd1);
        repeat (10) step();
        check("t3_valid_held", {31'd0, bus.out_valid}, 32'd1);
        check("t3_sum", {28'd0, bus.out_sum}, 32'd1);
        check("t3_cout", {31'd0, bus.out_cout}, 32'd1);
        check("t3_err", {31'd0, bus.out_err}, 32'd0);
        check("t3_dr_a_1", {28'd0, bus.dr_a_1}, 32'hF);
        check("t3_dr_b_0", {28'd0, bus.dr_b_0}, 32'hE);
        check("t3_dr_cin", {30'd0, bus.dr_cin_1, bus.dr_cin_0}, 32'd2);
        handshake();
        check("t3_dr_a_1_sp", {28'd0, bus.dr_a_1}, 32'd0);
        check("t3_dr_b_0_sp", {28'd0, bus.dr_b_0}, 32'd0);
        check("t3_dr_cin_sp", {30'd0, bus.dr_cin_1, bus.dr_cin_0}, 32'd0);
        wait_ready(4);

        // Skewed release with a one-cycle glitched value: 3 + 4 = 7
        mode = 1'b1;
        op_start(4'd3, 4'd4, 1'b0);
        step();
        m_s1 = 4'b0011; m_s0 = 4'b0000; m_c0 = 1'b1;
        step(); step();
        m_s0 = 4'b1100;
        step();
        m_s0 = 4'b1000;
        step(); step();
        m_s1 = 4'b0111;
        step(); step(); step();
        check("t4_valid_e9", {31'd0, bus.out_valid}, 32'd0);
        step();
        check("t4_valid_e10", {31'd0, bus.out_valid}, 32'd1);
        check("t4_sum", {28'd0, bus.out_sum}, 32'd7);
        check("t4_cout", {31'd0, bus.out_cout}, 32'd0);
        check("t4_err", {31'd0, bus.out_err}, 32'd0);
        handshake();
        m_s1 = '0; m_s0 = '0; m_c0 = 1'b0;
        wait_ready(4);

        // Illegal code on sum bit 2
        op_start(4'd1, 4'd2, 1'b0);
        m_s1 = 4'b0100; m_s0 = 4'b1111; m_c0 = 1'b1;
        step(); step();
        check("t5_valid_e2", {31'd0, bus.out_valid}, 32'd0);
        step();
        check("t5_valid_e3", {31'd0, bus.out_valid}, 32'd1);
        check("t5_err", {31'd0, bus.out_err}, 32'd1);
        check("t5_sum", {28'd0, bus.out_sum}, 32'd0);
        check("t5_cout", {31'd0, bus.out_cout}, 32'd0);
        handshake();
        m_s1 = '0; m_s0 = '0; m_c0 = 1'b0;
        wait_ready(4);
        check("t5_spacer_err", {31'd0, bus.spacer_err}, 32'd0);

        // Adder never completes: EVAL timeout
        op_start(4'd6, 4'd6, 1'b0);
        repeat (254) step();
        check("t6_valid_e254", {31'd0, bus.out_valid}, 32'd0);
        step();
        check("t6_valid_e255", {31'd0, bus.out_valid}, 32'd1);
        check("t6_err", {31'd0, bus.out_err}, 32'd1);
        check("t6_sum", {28'd0, bus.out_sum}, 32'd0);
        check("t6_dr_a_1", {28'd0, bus.dr_a_1}, 32'h6);

        // Adder stuck non-empty: SPACER timeout
        m_s1 = 4'b0001;
        handshake();
        repeat (254) step();
        check("t7_ready_h254", {31'd0, bus.in_ready}, 32'd0);
        check("t7_serr_h254", {31'd0, bus.spacer_err}, 32'd0);
        step();
        check("t7_ready_h255", {31'd0, bus.in_ready}, 32'd1);
        check("t7_serr_h255", {31'd0, bus.spacer_err}, 32'd1);
        repeat (5) step();
        check("t7_serr_sticky", {31'd0, bus.spacer_err}, 32'd1);
        rst = 1'b1;
        step();
        check("t7_serr_rst", {31'd0, bus.spacer_err}, 32'd0);
        check("t7_ready_rst", {31'd0, bus.in_ready}, 32'd0);
        m_s1 = '0;
        rst  = 1'b0;
        wait_ready(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
